// File: rtl/fir_out_stage.sv
// FIR output stage: round, scale and range-limit results, then queue them on a valid/ready stream.
// Define FIR_OUT_SAT_EN to saturate out-of-range results; otherwise they wrap to OUT_SIZE bits.
module fir_out_stage #(
  parameter int Y_N_SIZE = 11,
  parameter int OUT_SIZE = 8,
  parameter int SHIFT    = 3,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [Y_N_SIZE-1:0]   y_n,
  input  logic                         y_valid,
  input  logic                         clr_flags,
  output logic signed [OUT_SIZE-1:0]   m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [$clog2(DEPTH):0]       o_level,
  output logic                         o_ovf,
  output logic                         o_drop
);

  localparam int RW = Y_N_SIZE + 1;
  localparam int W  = RW + OUT_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic signed [RW-1:0] RND = RW'((1 << SHIFT) >> 1);
  localparam logic signed [W-1:0] MAXV =
    W'((64'sd1 <<< (OUT_SIZE - 1)) - 64'sd1);
  localparam logic signed [W-1:0] MINV = ~MAXV;

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] r;
  logic signed [W-1:0]  wide;
  logic                 oor;
  logic [OUT_SIZE-1:0]  res;

  logic                 s1_valid;
  logic [OUT_SIZE-1:0]  s1_data;

  logic [OUT_SIZE-1:0]  mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 full;
  logic                 pop;
  logic                 push_ok;

  assign ext  = {y_n[Y_N_SIZE-1], y_n};
  assign r    = (ext + RND) >>> SHIFT;
  assign wide = {{OUT_SIZE{r[RW-1]}}, r};
  assign oor  = (wide > MAXV) || (wide < MINV);

`ifdef FIR_OUT_SAT_EN
  always_comb begin
    res = wide[OUT_SIZE-1:0];
    if (oor)
      res = wide[W-1] ? MINV[OUT_SIZE-1:0] : MAXV[OUT_SIZE-1:0];
  end
`else
  assign res = wide[OUT_SIZE-1:0];
`endif

  assign full     = (level == LW'(DEPTH));
  assign m_tvalid = (level != '0);
  assign pop      = m_tvalid & m_tready;
  // A full FIFO still accepts when the head leaves on the same edge
  assign push_ok  = s1_valid & (~full | pop);
  assign m_tdata  = mem[rd_ptr];
  assign o_level  = level;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      o_ovf    <= 1'b0;
      o_drop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      s1_valid <= y_valid;
      if (y_valid)
        s1_data <= res;

      if (y_valid && oor)
        o_ovf <= 1'b1;
      else if (clr_flags)
        o_ovf <= 1'b0;

      if (s1_valid && !push_ok)
        o_drop <= 1'b1;
      else if (clr_flags)
        o_drop <= 1'b0;

      if (push_ok) begin
        mem[wr_ptr] <= s1_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      if (push_ok && !pop)
        level <= level + 1'b1;
      else if (!push_ok && pop)
        level <= level - 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage: rounding, range limiting, FIFO fill/drop,
// full-with-pop and mid-stream reset, all with hand-computed expectations.
module tb_fir_out_stage;

  logic              clk = 1'b0;
  logic              reset;
  logic [10:0]       y_n;
  logic              y_valid;
  logic              clr_flags;
  logic [7:0]        tdata;
  logic              tvalid;
  logic              tready;
  logic [2:0]        level;
  logic              ovf;
  logic              drop;

  int vectors = 0;
  int miscompares = 0;

`ifdef FIR_OUT_SAT_EN
  localparam logic [7:0] OVF_EXP = 8'h7F;
`else
  localparam logic [7:0] OVF_EXP = 8'h80;
`endif

  fir_out_stage dut (
    .clk       (clk),
    .reset     (reset),
    .y_n       (y_n),
    .y_valid   (y_valid),
    .clr_flags (clr_flags),
    .m_tdata   (tdata),
    .m_tvalid  (tvalid),
    .m_tready  (tready),
    .o_level   (level),
    .o_ovf     (ovf),
    .o_drop    (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe on one edge; returns at the negedge after stage 1 loads
  task automatic strobe(input logic [10:0] v);
    @(negedge clk);
    y_n = v;
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic expect_one(input string tag, input logic [7:0] d,
                            input logic f);
    check({tag, "_lat1"}, 32'(tvalid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(tvalid), 32'd1);
    check({tag, "_data"}, 32'(tdata), 32'(d));
    check({tag, "_ovf"}, 32'(ovf), 32'(f));
    @(negedge clk);
    check({tag, "_gone"}, 32'(tvalid), 32'd0);
  endtask

  initial begin
    logic [7:0] order [4];
    reset = 1'b1;
    y_n = '0;
    y_valid = 1'b0;
    clr_flags = 1'b0;
    tready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", 32'(tvalid), 32'd0);
    check("rst_data", 32'(tdata), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);

    strobe(11'd100);
    expect_one("round_pos", 8'd13, 1'b0);
    strobe(-11'sd100);
    expect_one("round_neg", 8'hF4, 1'b0);
    strobe(11'h400);
    expect_one("neg_limit", 8'h80, 1'b0);
    strobe(11'd1023);
    expect_one("ovf", OVF_EXP, 1'b1);
    pulse_clr();
    check("ovf_clr", 32'(ovf), 32'd0);

    tready = 1'b0;
    strobe(11'd8);
    strobe(11'd16);
    strobe(11'd24);
    strobe(11'd32);
    strobe(11'd40);
    @(negedge clk);
    check("fill_level", 32'(level), 32'd4);
    check("fill_drop", 32'(drop), 32'd1);
    check("fill_head", 32'(tdata), 32'd1);
    repeat (2) @(negedge clk);
    check("fill_hold", 32'(tdata), 32'd1);
    tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(tvalid), 32'd1);
      check("drain_data", 32'(tdata), 32'(i));
      @(negedge clk);
    end
    check("drain_empty", 32'(tvalid), 32'd0);
    check("drain_level", 32'(level), 32'd0);
    pulse_clr();
    check("drop_clr", 32'(drop), 32'd0);

    tready = 1'b0;
    strobe(11'd8);
    strobe(11'd16);
    strobe(11'd24);
    strobe(11'd32);
    @(negedge clk);
    check("full_level", 32'(level), 32'd4);
    y_n = 11'd80;
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
    tready = 1'b1;
    @(negedge clk);
    check("fpop_level", 32'(level), 32'd4);
    check("fpop_drop", 32'(drop), 32'd0);
    order[0] = 8'd2;
    order[1] = 8'd3;
    order[2] = 8'd4;
    order[3] = 8'd10;
    for (int i = 0; i < 4; i++) begin
      check("fpop_valid", 32'(tvalid), 32'd1);
      check("fpop_data", 32'(tdata), 32'(order[i]));
      @(negedge clk);
    end
    check("fpop_empty", 32'(tvalid), 32'd0);

    tready = 1'b0;
    strobe(11'd8);
    strobe(11'd16);
    strobe(11'd24);
    @(negedge clk);
    check("mid_level", 32'(level), 32'd3);
    y_n = 11'd1023;
    y_valid = 1'b1;
    @(negedge clk);
    y_valid = 1'b0;
    check("mid_ovf", 32'(ovf), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_valid", 32'(tvalid), 32'd0);
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_ovf", 32'(ovf), 32'd0);
    check("mrst_drop", 32'(drop), 32'd0);
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_stale", 32'(tvalid), 32'd0);
    end
    check("mrst_data", 32'(tdata), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/fir_out_stage.md
# fir_out_stage

Downstream output stage of the FIR datapath. It accepts each finished filter result together with a one-cycle strobe, then rounds, scales and range-limits it to the output pin width. Results queue in a small FIFO and leave on a valid/ready stream toward the pin multiplexer. Sticky status flags report out-of-range results and results lost to a full FIFO.

## Interface
Parameters:
- Y_N_SIZE, 11, width of the signed FIR result input
- OUT_SIZE, 8, width of the signed output word
- SHIFT, 3, arithmetic right shift applied before range limiting (0..Y_N_SIZE-1)
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- y_n  in  Y_N_SIZE  signed filter result, sampled only when y_valid=1
- y_valid  in  1  one-cycle strobe, one per finished result
- clr_flags  in  1  clears o_ovf and o_drop
- m_tdata  out  OUT_SIZE  signed head-of-FIFO word
- m_tvalid  out  1  FIFO non-empty
- m_tready  in  1  consumer accepts m_tdata
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- o_ovf  out  1  sticky flag: a scaled result exceeded the OUT_SIZE range
- o_drop  out  1  sticky flag: a result was discarded because the FIFO was full

## Operation
- Stage 1, processing register:
  - When y_valid=1, compute r = (sign-extend(y_n) to Y_N_SIZE+1 bits + 2^(SHIFT-1)) >>> SHIFT. This is round-half-up. With SHIFT=0, no rounding constant is added.
  - Range-limit r to OUT_SIZE bits (see Configuration) and register the result with s1_valid.
  - The range check is r > 2^(OUT_SIZE-1)-1 or r < -2^(OUT_SIZE-1). On a violation, o_ovf is set on the same edge that loads stage 1.
- Stage 2, FIFO:
  - Circular buffer with read/write pointers and an occupancy counter.
  - push = s1_valid; pop = m_tvalid & m_tready.
  - A push is accepted when level < DEPTH, or when level = DEPTH and pop=1 in the same cycle.
  - A push that is not accepted is discarded and sets o_drop.
- Simultaneous push and pop:
  - Level is unchanged.
  - Both pointers advance; the read pointer wraps modulo DEPTH, and so does the write pointer.
- Pop with no push: level decrements. Pop on an empty FIFO cannot occur because m_tvalid=0.
- m_tdata always shows the entry at the read pointer. It must not change while m_tvalid=1 and m_tready=0.
- No bypass: an empty FIFO still takes the full pipeline latency.
- clr_flags=1 clears both sticky flags. If a flag-setting event occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - m_tvalid=0, m_tdata=0, o_level=0, o_ovf=0, o_drop=0.
  - s1_valid=0; pointers 0.
  - FIFO contents are don't-care, but m_tdata must read 0 until the first push.
- Latency: y_valid sampled at edge E0 → stage 1 loaded at E0 → FIFO written at E1 → m_tvalid=1 after E1. That is 2 cycles from strobe to valid.
- Throughput: one result per cycle sustained when m_tready=1.
- y_valid on consecutive cycles is legal. Each strobe produces exactly one push attempt.
- Reset mid-operation: the in-flight stage 1 result and all queued entries are discarded. Outputs return to their reset values on the next edge.
- o_level updates on the same edge as the push or pop that changes it.

## Configuration
- Macro: FIR_OUT_SAT_EN.
- Defined: out-of-range r saturates to 2^(OUT_SIZE-1)-1 or -2^(OUT_SIZE-1).
- Undefined: out-of-range r is truncated to its low OUT_SIZE bits (two's-complement wrap).
- o_ovf detection is identical in both builds.

## Test plan
All scenarios use default parameters.
- Rounding: y_n=100, y_valid pulse, m_tready=1 → m_tdata=13 with m_tvalid high exactly 2 cycles after the strobe; o_ovf=0.
- Negative rounding: y_n=-100 → m_tdata=-12 (0xF4). Then y_n=-1024 → m_tdata=-128 (0x80) with o_ovf=0.
- Overflow: y_n=1023 → with FIR_OUT_SAT_EN, m_tdata=127 (0x7F) and o_ovf=1; without it, m_tdata=-128 (0x80) and o_ovf=1. clr_flags pulse → o_ovf=0.
- Fill and drop:
  - m_tready=0; strobes with y_n=8,16,24,32,40 → o_level=4, o_drop=1, m_tdata=1 held steady.
  - Raise m_tready → 1,2,3,4 emitted in order, then m_tvalid=0 and o_level=0.
- Full with simultaneous pop: FIFO full; same cycle push y_n=80 with m_tready=1 → o_level stays 4, o_drop stays 0, and the value 10 appears after the 3 older entries.
- Reset mid-stream: 3 entries queued plus a strobe in flight; assert reset for 1 cycle → m_tvalid=0, o_level=0, flags 0, and no stale word appears afterward.
